// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the modulo counter family.
//   DIR_UP / DIR_DOWN : encodings of the counter direction input
//   terminalValue()   : last value of a modulo-N sequence (N-1)
//   legalRange()      : parameter legality check reused by later counter blocks
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_WIDTH = 16;

  // Highest count value before the sequence wraps back to zero.
  function automatic int terminalValue(input int modulus);
    return modulus - 1;
  endfunction

  // Width must be 1..16 and the modulus must fit in the width with at
  // least two states in the sequence.
  function automatic bit legalRange(input int width, input int modulus);
    if (width < 1 || width > MAX_WIDTH) return 1'b0;
    if (modulus < 2 || modulus > (2 ** width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// tff_mod_counter_if
// Control and status bundle of the modulo counter.
//   en, up, load, load_val : driven by the controlling block (master)
//   q, wrap                : driven by the counter (slave)
interface tff_mod_counter_if #(
  parameter int WIDTH = 3
);
  import counter_pkg::*;

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  q, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output q, wrap
  );

endinterface

// File: rtl/tff_sync.sv
// tff_sync
// Single T flip-flop with synchronous active-high reset.
//   sysclk : clock, rising edge
//   rstn   : synchronous reset, active high (clears q)
//   t      : toggle enable
//   q      : stored bit
module tff_sync (
  input  logic sysclk,
  input  logic rstn,
  input  logic t,
  output logic q
);

  logic r_q;

  // Reset wins over toggle; otherwise the bit inverts whenever t is high.
  always_ff @(posedge sysclk) begin
    if (rstn) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter
// Modulo-N up/down counter built from a chain of T flip-flops, with count
// enable, synchronous parallel load (clamped to N-1) and a registered wrap flag.
//   sysclk        : clock, rising edge
//   rstn          : synchronous reset, active high
//   bus.en        : count enable
//   bus.up        : direction, 1 = up, 0 = down
//   bus.load      : parallel load strobe (beats en)
//   bus.load_val  : value to load
//   bus.q         : current count
//   bus.wrap      : high for the one cycle in which q shows a wrapped value
module tff_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                   sysclk,
  input  logic                   rstn,
  tff_mod_counter_if.slave       bus
);

  if (!legalRange(WIDTH, MODULUS)) begin : g_badParams
    $error("tff_mod_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(terminalValue(MODULUS));

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_upAll;
  logic [WIDTH-1:0] w_dnAll;
  logic [WIDTH-1:0] w_loadVal;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_toggle;
  logic             w_countUp;
  logic             w_wrapUp;
  logic             w_wrapDown;
  logic             w_useTarget;
  logic             r_wrap;

  // Out-of-range loads clamp to the terminal value so q never leaves the sequence.
  assign w_loadVal = (bus.load_val > TERM) ? TERM : bus.load_val;

  assign w_countUp  = (bus.up == DIR_UP);
  assign w_wrapUp   = bus.en &&  w_countUp && (w_q == TERM);
  assign w_wrapDown = bus.en && !w_countUp && (w_q == '0);

  // Load and wrap both jump to an absolute value; the T chain reaches it by
  // toggling exactly the bits that differ from the current count.
  always_comb begin
    w_target = '0;
    if (bus.load) begin
      w_target = w_loadVal;
    end else if (w_wrapDown) begin
      w_target = TERM;
    end
  end

  assign w_useTarget = bus.load || w_wrapUp || w_wrapDown;

  // Ordinary steps use the classic ripple-enable rule: a bit toggles when all
  // lower bits are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    w_toggle = '0;
    if (w_useTarget) begin
      w_toggle = w_q ^ w_target;
    end else if (bus.en) begin
      w_toggle = w_countUp ? w_upAll : w_dnAll;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign w_upAll[gi] = 1'b1;
      assign w_dnAll[gi] = 1'b1;
    end else begin : g_chain
      assign w_upAll[gi] = w_upAll[gi-1] &  w_q[gi-1];
      assign w_dnAll[gi] = w_dnAll[gi-1] & ~w_q[gi-1];
    end

    tff_sync u_tff (
      .sysclk (sysclk),
      .rstn   (rstn),
      .t      (w_toggle[gi]),
      .q      (w_q[gi])
    );
  end

  // Wrap flag is registered alongside the count so it lines up with the
  // wrapped q value; load and hold both clear it.
  always_ff @(posedge sysclk) begin
    if (rstn) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= !bus.load && (w_wrapUp || w_wrapDown);
    end
  end

  assign bus.q    = w_q;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter
// Directed bench for three counter configurations: WIDTH=3/MODULUS=8,
// WIDTH=4/MODULUS=10 and WIDTH=1/MODULUS=2.
module tb_tff_mod_counter;

  logic sysclk = 1'b0;
  logic rst8   = 1'b1;
  logic rst10  = 1'b1;
  logic rst2   = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 sysclk = ~sysclk;

  tff_mod_counter_if #(.WIDTH(3)) bus8  ();
  tff_mod_counter_if #(.WIDTH(4)) bus10 ();
  tff_mod_counter_if #(.WIDTH(1)) bus2  ();

  tff_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .sysclk (sysclk),
    .rstn   (rst8),
    .bus    (bus8.slave)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .sysclk (sysclk),
    .rstn   (rst10),
    .bus    (bus10.slave)
  );

  tff_mod_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .sysclk (sysclk),
    .rstn   (rst2),
    .bus    (bus2.slave)
  );

  // Advance the given number of rising edges and settle just after the last.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Step dut10 once with the given controls and check q / wrap.
  task automatic step10(input string tag, input logic en, input logic up,
                        input logic load, input int loadVal,
                        input int expQ, input int expWrap);
    bus10.en       = en;
    bus10.up       = up;
    bus10.load     = load;
    bus10.load_val = 4'(loadVal);
    applyStimulus(1);
    checkOutput({tag, " q"},    int'(bus10.q),    expQ);
    checkOutput({tag, " wrap"}, int'(bus10.wrap), expWrap);
  endtask

  initial begin
    bus8.en  = 1'b0; bus8.up  = 1'b1; bus8.load  = 1'b0; bus8.load_val  = '0;
    bus10.en = 1'b0; bus10.up = 1'b1; bus10.load = 1'b0; bus10.load_val = '0;
    bus2.en  = 1'b0; bus2.up  = 1'b1; bus2.load  = 1'b0; bus2.load_val  = '0;

    // Reset state of all three instances.
    applyStimulus(1);
    checkOutput("rst8 q",     int'(bus8.q),     0);
    checkOutput("rst8 wrap",  int'(bus8.wrap),  0);
    checkOutput("rst10 q",    int'(bus10.q),    0);
    checkOutput("rst10 wrap", int'(bus10.wrap), 0);
    checkOutput("rst2 q",     int'(bus2.q),     0);
    checkOutput("rst2 wrap",  int'(bus2.wrap),  0);

    // MODULUS=8 up count: 1..7,0,1,2 with wrap only on q=0.
    rst8 = 1'b0;
    bus8.en = 1'b1;
    bus8.up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("m8 up%0d q", k),    int'(bus8.q),    k % 8);
      checkOutput($sformatf("m8 up%0d wrap", k), int'(bus8.wrap), (k == 8) ? 1 : 0);
    end

    // MODULUS=8 down from 2: 1, 0, then wrap to 7.
    bus8.up = 1'b0;
    applyStimulus(1);
    checkOutput("m8 dn q1", int'(bus8.q), 1);
    applyStimulus(1);
    checkOutput("m8 dn q0", int'(bus8.q), 0);
    checkOutput("m8 dn w0", int'(bus8.wrap), 0);
    applyStimulus(1);
    checkOutput("m8 dn q7", int'(bus8.q), 7);
    checkOutput("m8 dn w7", int'(bus8.wrap), 1);

    // Load beats enable; in-range value passes unchanged.
    bus8.load = 1'b1;
    bus8.load_val = 3'd5;
    applyStimulus(1);
    checkOutput("m8 load q",    int'(bus8.q),    5);
    checkOutput("m8 load wrap", int'(bus8.wrap), 0);
    bus8.load = 1'b0;
    bus8.en = 1'b0;

    // MODULUS=10 up count: 1..9,0,1,2, value 10 never reached.
    rst10 = 1'b0;
    bus10.en = 1'b1;
    bus10.up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("m10 up%0d q", k),    int'(bus10.q),    k % 10);
      checkOutput($sformatf("m10 up%0d wrap", k), int'(bus10.wrap), (k == 10) ? 1 : 0);
    end

    // Reset then count down: 9 (wrap), 8, 7.
    rst10 = 1'b1;
    applyStimulus(1);
    checkOutput("m10 rst q", int'(bus10.q), 0);
    rst10 = 1'b0;
    step10("m10 dn9", 1'b1, 1'b0, 1'b0, 0, 9, 1);
    step10("m10 dn8", 1'b1, 1'b0, 1'b0, 0, 8, 0);
    step10("m10 dn7", 1'b1, 1'b0, 1'b0, 0, 7, 0);

    // Out-of-range load clamps to 9, then one up step wraps.
    step10("m10 clamp",  1'b1, 1'b1, 1'b1, 12, 9, 0);
    step10("m10 wrapup", 1'b1, 1'b1, 1'b0, 0,  0, 1);
    step10("m10 hold",   1'b0, 1'b1, 1'b0, 0,  0, 0);

    // Reset overrides load and enable mid-count, then counting resumes.
    step10("m10 ld4",  1'b0, 1'b1, 1'b1, 4, 4, 0);
    step10("m10 to5",  1'b1, 1'b1, 1'b0, 0, 5, 0);
    rst10 = 1'b1;
    step10("m10 rstld", 1'b1, 1'b1, 1'b1, 3, 0, 0);
    rst10 = 1'b0;
    step10("m10 res1", 1'b1, 1'b1, 1'b0, 0, 1, 0);
    step10("m10 res2", 1'b1, 1'b1, 1'b0, 0, 2, 0);
    step10("m10 res3", 1'b1, 1'b1, 1'b0, 0, 3, 0);

    // Enable 1,0,0,1 with direction flipped between enabled steps: 4,4,4,3.
    step10("m10 en1", 1'b1, 1'b1, 1'b0, 0, 4, 0);
    step10("m10 en0", 1'b0, 1'b0, 1'b0, 0, 4, 0);
    step10("m10 en0b", 1'b0, 1'b0, 1'b0, 0, 4, 0);
    step10("m10 en1b", 1'b1, 1'b0, 1'b0, 0, 3, 0);
    bus10.en = 1'b0;

    // MODULUS=2: 0->1 up is a normal step, then alternating direction wraps
    // on every edge.
    rst2 = 1'b0;
    bus2.en = 1'b1;
    bus2.up = 1'b1;
    applyStimulus(1);
    checkOutput("m2 s1 q",    int'(bus2.q),    1);
    checkOutput("m2 s1 wrap", int'(bus2.wrap), 0);
    applyStimulus(1);
    checkOutput("m2 s2 q",    int'(bus2.q),    0);
    checkOutput("m2 s2 wrap", int'(bus2.wrap), 1);
    bus2.up = 1'b0;
    applyStimulus(1);
    checkOutput("m2 s3 q",    int'(bus2.q),    1);
    checkOutput("m2 s3 wrap", int'(bus2.wrap), 1);
    bus2.up = 1'b1;
    applyStimulus(1);
    checkOutput("m2 s4 q",    int'(bus2.q),    0);
    checkOutput("m2 s4 wrap", int'(bus2.wrap), 1);
    bus2.up = 1'b0;
    applyStimulus(1);
    checkOutput("m2 s5 q",    int'(bus2.q),    1);
    checkOutput("m2 s5 wrap", int'(bus2.wrap), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
